// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_feeder
// Purpose : FIFO-buffered byte sequencer feeding a UART transmitter.
// Rev     : 1.0
// ============================================================================
module uart_tx_feeder #(
    parameter int DBITS  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DBITS-1:0]  wr_data,
    input  logic              ovf_clr,
    input  logic              tx_done_tick,
    output logic              tx_start,
    output logic [DBITS-1:0]  tx_din,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              overflow
);

    localparam int             DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] C_FULL = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t              state_q,    state_d;
    logic [ADDR_W-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [ADDR_W:0]     count_q,    count_d;
    logic                tx_start_q, tx_start_d;
    logic [DBITS-1:0]    tx_din_q,   tx_din_d;
    logic                overflow_q, overflow_d;

    logic [DBITS-1:0]    mem_q [DEPTH];

    logic                full_c;
    logic                empty_c;
    logic                wr_accept;
    logic                wr_drop;
    logic                pop;

    // Full is judged on the current occupancy, so a pop in the same cycle
    // never makes room for a write to a full FIFO.
    assign full_c    = (count_q == C_FULL);
    assign empty_c   = (count_q == '0);
    assign wr_accept = wr_en && !full_c;
    assign wr_drop   = wr_en &&  full_c;
    assign pop       = (state_q == IDLE) && !empty_c;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        tx_start_d = 1'b0;
        tx_din_d   = tx_din_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    tx_din_d   = mem_q[rd_ptr_q];
                    rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
                    tx_start_d = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (tx_done_tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end

        case ({wr_accept, pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase

        // A dropped write in the same cycle as a clear leaves the flag set.
        if (wr_drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_start_q <= 1'b0;
            tx_din_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_start_q <= tx_start_d;
            tx_din_q   <= tx_din_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_din   = tx_din_q;
    assign full     = full_c;
    assign empty    = empty_c;
    assign count    = count_q;
    assign busy     = (state_q == WAIT);
    assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_feeder
// Purpose : Scoreboard bench for uart_tx_feeder with a simple transmitter stub.
// Rev     : 1.0
// ============================================================================
module tb_uart_tx_feeder;

    localparam int DBITS  = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int FRAME  = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [DBITS-1:0]  wr_data;
    logic              ovf_clr;
    logic              tx_done_tick;
    logic              tx_start;
    logic [DBITS-1:0]  tx_din;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              overflow;

    logic auto_done = 1'b0;
    logic man_done  = 1'b0;
    logic hold_tx   = 1'b0;
    logic gap_chk   = 1'b0;
    assign tx_done_tick = auto_done | man_done;

    uart_tx_feeder #(.DBITS(DBITS), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .ovf_clr      (ovf_clr),
        .tx_done_tick (tx_done_tick),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .busy         (busy),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference model of occupancy, state and flags; scoreboard holds accepted bytes.
    logic [7:0] sb[$];
    int         m_cnt;
    logic       m_busy, m_start, m_ovf;
    logic       m_acc, m_drop, m_pop;
    assign m_acc  = wr_en && (m_cnt != DEPTH);
    assign m_drop = wr_en && (m_cnt == DEPTH);
    assign m_pop  = !m_busy && (m_cnt != 0);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt   <= 0;
            m_busy  <= 1'b0;
            m_start <= 1'b0;
            m_ovf   <= 1'b0;
            sb.delete();
        end else begin
            m_start <= m_pop;
            if (m_pop)                      m_busy <= 1'b1;
            else if (m_busy && tx_done_tick) m_busy <= 1'b0;
            m_cnt <= m_cnt + (m_acc ? 1 : 0) - (m_pop ? 1 : 0);
            if (m_drop)       m_ovf <= 1'b1;
            else if (ovf_clr) m_ovf <= 1'b0;
            if (m_acc) sb.push_back(wr_data);
        end
    end

    int         n_starts   = 0;
    int         done_cyc   = 0;
    logic       done_valid = 1'b0;
    logic [7:0] cur_din    = 8'h00;
    logic [7:0] exp_b;

    always @(negedge clk) begin
        check("count",    32'(count),    32'(m_cnt));
        check("full",     32'(full),     32'(m_cnt == DEPTH));
        check("empty",    32'(empty),    32'(m_cnt == 0));
        check("busy",     32'(busy),     32'(m_busy));
        check("tx_start", 32'(tx_start), 32'(m_start));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (tx_done_tick && m_busy && gap_chk) begin
            done_cyc   = cyc;
            done_valid = 1'b1;
        end
        if (tx_start) begin
            n_starts++;
            if (gap_chk && done_valid) check("start_gap", 32'(cyc - done_cyc), 32'd2);
            done_valid = 1'b0;
            check("sb_has_data", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_b = sb.pop_front();
                check("tx_din_order", 32'(tx_din), 32'(exp_b));
                cur_din = exp_b;
            end
        end else if (busy) begin
            check("tx_din_hold", 32'(tx_din), 32'(cur_din));
        end
    end

    // Transmitter stub: one line bit per cycle, done on the stop bit.
    logic       active = 1'b0;
    int         ph     = 0;
    logic [9:0] line_cap = '0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            auto_done = 1'b0;
            if (!reset) begin
                active = 1'b0;
                ph     = 0;
            end else if (tx_start) begin
                active = 1'b1;
                ph     = 0;
            end else if (active && !hold_tx) begin
                if (ph == FRAME - 1) active = 1'b0;
                else                 ph     = ph + 1;
            end
            if (active) begin
                line_cap[ph] = (ph == 0) ? 1'b0 : (ph == FRAME - 1) ? 1'b1 : tx_din[ph-1];
                auto_done    = (ph == FRAME - 1) && !hold_tx;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_drain(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (empty && !busy) break;
            tick();
        end
        check("drain_timeout", 32'(empty && !busy), 32'd1);
    endtask

    task automatic wait_busy(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (busy) break;
            tick();
        end
        check("busy_timeout", 32'(busy), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int s0;
    initial begin
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        ovf_clr = 1'b0;
        repeat (3) tick();
        check("rst_count",    32'(count),    32'd0);
        check("rst_empty",    32'(empty),    32'd1);
        check("rst_full",     32'(full),     32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_din",   32'(tx_din),   32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b1;

        // Single byte with exact latency and serial framing
        while (cyc < 10) tick();
        wr(8'hA5);
        check("t1_count_n1", 32'(count),    32'd1);
        check("t1_start_n1", 32'(tx_start), 32'd0);
        tick();
        check("t1_start_n2", 32'(tx_start), 32'd1);
        check("t1_din_n2",   32'(tx_din),   32'hA5);
        check("t1_busy_n2",  32'(busy),     32'd1);
        tick();
        check("t1_start_n3", 32'(tx_start), 32'd0);
        wait_drain(40);
        check("t1_line", 32'(line_cap), 32'(10'b1101001010));

        // Burst ordering and done-to-start spacing
        gap_chk = 1'b1;
        s0 = n_starts;
        for (int i = 1; i <= 5; i++) wr(8'(i));
        wait_drain(100);
        check("burst_starts", 32'(n_starts - s0), 32'd5);
        check("burst_empty",  32'(empty),         32'd1);
        gap_chk = 1'b0;

        // Fill while the transmitter is stalled, then overflow handling
        hold_tx = 1'b1;
        wr(8'h10);
        wait_busy(10);
        for (int i = 0; i < 17; i++) wr(8'h20 + 8'(i));
        check("ovf_full",  32'(full),     32'd1);
        check("ovf_count", 32'(count),    32'd16);
        check("ovf_flag",  32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
        wr_en   = 1'b1;
        wr_data = 8'h99;
        ovf_clr = 1'b1;
        tick();
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        check("ovf_set_wins", 32'(overflow), 32'd1);
        check("ovf_count2",   32'(count),    32'd16);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        hold_tx = 1'b0;
        wait_drain(16 * 12 + 40);

        // Pointer wrap with writes landing during WAIT
        s0 = n_starts;
        for (int i = 0; i < 40; i++) begin
            wr(8'(i));
            repeat (7) tick();
        end
        wait_drain(600);
        check("wrap_starts", 32'(n_starts - s0), 32'd40);
        check("wrap_sb",     32'(sb.size()),     32'd0);

        // Spurious done in IDLE with an empty FIFO
        s0 = n_starts;
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        check("spur_busy",  32'(busy),  32'd0);
        check("spur_count", 32'(count), 32'd0);
        repeat (2) tick();
        check("spur_starts", 32'(n_starts - s0), 32'd0);

        // Write landing in the pop cycle keeps count steady
        hold_tx = 1'b1;
        wr(8'h40);
        wait_busy(10);
        wr(8'h41);
        wr(8'h42);
        wr(8'h43);
        check("sim_count_pre", 32'(count), 32'd3);
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        check("sim_idle", 32'(busy),  32'd0);
        check("sim_cnt3", 32'(count), 32'd3);
        wr(8'h44);
        check("sim_count_post", 32'(count),    32'd3);
        check("sim_start",      32'(tx_start), 32'd1);
        hold_tx = 1'b0;
        wait_drain(100);

        // Asynchronous reset in WAIT with data queued
        hold_tx = 1'b1;
        for (int i = 0; i < 5; i++) wr(8'h60 + 8'(i));
        for (int i = 0; i < 10; i++) begin
            if (count == 5'd4 && busy) break;
            tick();
        end
        check("pre_rst_count", 32'(count), 32'd4);
        reset = 1'b0;
        #1;
        check("arst_tx_start", 32'(tx_start), 32'd0);
        check("arst_tx_din",   32'(tx_din),   32'd0);
        check("arst_count",    32'(count),    32'd0);
        check("arst_busy",     32'(busy),     32'd0);
        check("arst_empty",    32'(empty),    32'd1);
        repeat (2) tick();
        reset   = 1'b1;
        hold_tx = 1'b0;
        s0 = n_starts;
        repeat (6) tick();
        check("post_rst_quiet", 32'(n_starts - s0), 32'd0);
        wr(8'h5A);
        wait_drain(40);
        check("post_rst_start", 32'(n_starts - s0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
